// File: rtl/pipe_hazard_seq.sv
// ============================================================================
// Module  : pipe_hazard_seq
// Brief   : Stall/flush sequencer for a 5-stage RV32 pipeline with redirect,
//           load-use, multi-cycle execute and data-memory wait handling.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_seq #(
  parameter int CNT_W      = 32,
  parameter int EX_TIMEOUT = 64,
  parameter int TO_W       = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       pc_src,
  input  logic             load_use,
  input  logic             ex_start,
  input  logic             ex_done,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             ctr_clr,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic [1:0]       busy_state,
  output logic             ex_timeout_err,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_EX_WAIT  = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_t;

  localparam logic [TO_W-1:0]  C_TO_LAST = TO_W'(EX_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  C_TO_ONE  = TO_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic w_major;
  logic w_minor;
  logic w_eval;
  logic w_redir;

  assign w_major = (pc_src == 3'b010) || (pc_src == 3'b011) || (pc_src == 3'b101);
  assign w_minor = (pc_src == 3'b001);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      to_q        <= '0;
      err_q       <= 1'b0;
      redir_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      to_q        <= to_d;
      err_q       <= err_d;
      redir_cnt_q <= redir_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    err_d   = err_q;
    w_eval  = 1'b0;
    w_redir = 1'b0;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          state_d = ST_MEM_WAIT;
        end else if (ex_start) begin
          {stall_f, stall_d, stall_e} = 3'b111;
          flush_m = 1'b1;
          to_d    = '0;
          state_d = ST_EX_WAIT;
        end else begin
          w_eval = 1'b1;
        end
      end
      ST_EX_WAIT: begin
        if (ex_done) begin
          w_eval  = 1'b1;
          state_d = ST_RUN;
        end else if (to_q == C_TO_LAST) begin
          // Hung unit: release the pipe and drop the op sitting in E.
          flush_e = 1'b1;
          err_d   = 1'b1;
          state_d = ST_RUN;
        end else begin
          {stall_f, stall_d, stall_e} = 3'b111;
          flush_m = 1'b1;
          to_d    = to_q + C_TO_ONE;
        end
      end
      ST_MEM_WAIT: begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        if (mem_ack) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (w_eval) begin
      if (w_major) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
        w_redir = 1'b1;
      end else if (w_minor) begin
        flush_e = 1'b1;
        w_redir = 1'b1;
        if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
        end
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end

    if (!rst_n) begin
      {stall_f, stall_d, stall_e, stall_m} = 4'b0000;
      {flush_d, flush_e, flush_m}          = 3'b111;
      w_redir = 1'b0;
    end

    redir_cnt_d = redir_cnt_q;
    if (ctr_clr) begin
      redir_cnt_d = '0;
    end else if (w_redir && (redir_cnt_q != C_CNT_MAX)) begin
      redir_cnt_d = redir_cnt_q + C_CNT_ONE;
    end

    stall_cnt_d = stall_cnt_q;
    if (ctr_clr) begin
      stall_cnt_d = '0;
    end else if (stall_f && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + C_CNT_ONE;
    end
  end

  assign busy_state     = state_q;
  assign ex_timeout_err = err_q;
  assign redirect_cnt   = redir_cnt_q;
  assign stall_cnt      = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_seq.sv
// ============================================================================
// Module  : tb_pipe_hazard_seq
// Brief   : Directed vector bench for pipe_hazard_seq (default and small-param
//           instances sharing one stimulus).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] pc_src;
  logic       load_use, ex_start, ex_done, mem_req, mem_ack, ctr_clr;

  logic        a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fm, a_err;
  logic [1:0]  a_bs;
  logic [31:0] a_rc, a_sc;

  logic        b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fm, b_err;
  logic [1:0]  b_bs;
  logic [2:0]  b_rc, b_sc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_seq u_dut_a (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .load_use(load_use),
    .ex_start(ex_start), .ex_done(ex_done), .mem_req(mem_req), .mem_ack(mem_ack),
    .ctr_clr(ctr_clr), .stall_f(a_sf), .stall_d(a_sd), .stall_e(a_se), .stall_m(a_sm),
    .flush_d(a_fd), .flush_e(a_fe), .flush_m(a_fm), .busy_state(a_bs),
    .ex_timeout_err(a_err), .redirect_cnt(a_rc), .stall_cnt(a_sc)
  );

  pipe_hazard_seq #(.CNT_W(3), .EX_TIMEOUT(4), .TO_W(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .load_use(load_use),
    .ex_start(ex_start), .ex_done(ex_done), .mem_req(mem_req), .mem_ack(mem_ack),
    .ctr_clr(ctr_clr), .stall_f(b_sf), .stall_d(b_sd), .stall_e(b_se), .stall_m(b_sm),
    .flush_d(b_fd), .flush_e(b_fe), .flush_m(b_fm), .busy_state(b_bs),
    .ex_timeout_err(b_err), .redirect_cnt(b_rc), .stall_cnt(b_sc)
  );

  typedef struct {
    logic [2:0] pc;
    logic       lu, exs, exd, mrq, mak, clr;
    logic [3:0] st;
    logic [2:0] fl;
    logic [1:0] bs;
    int         rc;
    int         sc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic [2:0] pc, input logic lu, exs, exd, mrq, mak, clr,
                     input logic [3:0] st, input logic [2:0] fl, input logic [1:0] bs,
                     input int rc, input int sc);
    vec_t v;
    v.pc = pc; v.lu = lu; v.exs = exs; v.exd = exd; v.mrq = mrq; v.mak = mak; v.clr = clr;
    v.st = st; v.fl = fl; v.bs = bs; v.rc = rc; v.sc = sc;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [2:0] pc, input logic lu, exs, exd, mrq, mak, clr);
    pc_src = pc; load_use = lu; ex_start = exs; ex_done = exd;
    mem_req = mrq; mem_ack = mak; ctr_clr = clr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset right away, checks the reset values, and releases it 1ns
  // after the next rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_stalls_a", {a_sf, a_sd, a_se, a_sm}, 4'b0000);
    chk("rst_flushes_a", {a_fd, a_fe, a_fm}, 3'b111);
    chk("rst_busy_a", a_bs, 2'b00);
    chk("rst_rc_a", a_rc, 0);
    chk("rst_sc_a", a_sc, 0);
    chk("rst_err_b", b_err, 0);
    chk("rst_rc_b", b_rc, 0);
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    add(3'b011, 1,0,0,0,0,0, 4'b0000, 3'b110, 2'b00, 0, 0);
    add(3'b000, 1,0,0,0,0,0, 4'b1100, 3'b010, 2'b00, 1, 0);
    add(3'b000, 0,0,0,0,0,0, 4'b0000, 3'b000, 2'b00, 1, 1);
    add(3'b001, 0,0,0,0,0,0, 4'b0000, 3'b010, 2'b00, 1, 1);
    add(3'b001, 1,0,0,0,0,0, 4'b1100, 3'b010, 2'b00, 2, 1);
    add(3'b100, 0,0,0,0,0,0, 4'b0000, 3'b000, 2'b00, 3, 2);
    add(3'b101, 0,0,0,0,0,0, 4'b0000, 3'b110, 2'b00, 3, 2);
    add(3'b110, 1,0,0,0,0,0, 4'b1100, 3'b010, 2'b00, 4, 2);
    add(3'b000, 0,0,0,1,1,0, 4'b0000, 3'b000, 2'b00, 4, 3);
    add(3'b000, 0,0,0,0,0,1, 4'b0000, 3'b000, 2'b00, 4, 3);
    add(3'b000, 0,0,0,0,0,0, 4'b0000, 3'b000, 2'b00, 0, 0);
    // memory wait with a major redirect held throughout
    add(3'b010, 0,0,0,1,0,0, 4'b1111, 3'b000, 2'b00, 0, 0);
    add(3'b010, 0,0,0,1,0,0, 4'b1111, 3'b000, 2'b10, 0, 1);
    add(3'b010, 1,0,0,1,0,0, 4'b1111, 3'b000, 2'b10, 0, 2);
    add(3'b010, 0,0,0,1,1,0, 4'b1111, 3'b000, 2'b10, 0, 3);
    add(3'b010, 0,0,0,0,0,0, 4'b0000, 3'b110, 2'b00, 0, 4);
    add(3'b000, 0,0,0,0,0,0, 4'b0000, 3'b000, 2'b00, 1, 4);
    add(3'b011, 0,0,0,0,0,1, 4'b0000, 3'b110, 2'b00, 1, 4);
    add(3'b000, 0,0,0,0,0,0, 4'b0000, 3'b000, 2'b00, 0, 0);
    // multi-cycle op, done on the 5th following cycle
    add(3'b010, 0,1,1,0,0,0, 4'b1110, 3'b001, 2'b00, 0, 0);
    add(3'b011, 0,0,0,0,0,0, 4'b1110, 3'b001, 2'b01, 0, 1);
    add(3'b000, 1,0,0,1,0,0, 4'b1110, 3'b001, 2'b01, 0, 2);
    add(3'b000, 0,0,0,0,0,0, 4'b1110, 3'b001, 2'b01, 0, 3);
    add(3'b000, 0,0,0,0,0,0, 4'b1110, 3'b001, 2'b01, 0, 4);
    add(3'b011, 1,0,1,0,0,0, 4'b0000, 3'b110, 2'b01, 0, 5);
    add(3'b000, 0,0,0,0,0,0, 4'b0000, 3'b000, 2'b00, 1, 5);

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].pc, tbl[i].lu, tbl[i].exs, tbl[i].exd, tbl[i].mrq, tbl[i].mak, tbl[i].clr);
      #4;
      chk($sformatf("v%0d_stalls", i), {a_sf, a_sd, a_se, a_sm}, tbl[i].st);
      chk($sformatf("v%0d_flushes", i), {a_fd, a_fe, a_fm}, tbl[i].fl);
      chk($sformatf("v%0d_busy", i), a_bs, tbl[i].bs);
      chk($sformatf("v%0d_redirect_cnt", i), a_rc, tbl[i].rc);
      chk($sformatf("v%0d_stall_cnt", i), a_sc, tbl[i].sc);
      next_cycle();
    end

    // Timeout on the small instance: 4 EX_WAIT cycles, the last one releasing.
    do_reset();
    drive(3'b000, 0, 1, 0, 0, 0, 0);
    #4;
    chk("to_start_stalls", {b_sf, b_sd, b_se, b_sm}, 4'b1110);
    next_cycle();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #4;
      chk($sformatf("to_wait%0d_busy", k), b_bs, 2'b01);
      chk($sformatf("to_wait%0d_outs", k), {b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fm}, 7'b1110001);
      next_cycle();
    end
    #4;
    chk("to_exit_busy", b_bs, 2'b01);
    chk("to_exit_outs", {b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fm}, 7'b0000010);
    chk("to_exit_err_pre", b_err, 0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      #4;
      chk($sformatf("to_sticky%0d_err", k), b_err, 1);
      chk($sformatf("to_sticky%0d_busy", k), b_bs, 2'b00);
      next_cycle();
    end

    // Saturation of the 3-bit redirect counter, then clear beating a redirect.
    do_reset();
    chk("sat_err_cleared", b_err, 0);
    for (int k = 0; k < 8; k++) begin
      drive(3'b010, 0, 0, 0, 0, 0, 0);
      #4;
      if (k == 7) chk("sat_rc_at7", b_rc, 7);
      next_cycle();
    end
    drive(3'b011, 0, 0, 0, 0, 0, 1);
    #4;
    chk("sat_rc_held", b_rc, 7);
    chk("clr_redirect_flush", {b_fd, b_fe}, 2'b11);
    next_cycle();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    #4;
    chk("clr_rc_b", b_rc, 0);
    next_cycle();

    // Reset asserted in the middle of MEM_WAIT.
    drive(3'b000, 0, 0, 0, 1, 0, 0);
    next_cycle();
    #3;
    chk("mrst_busy_before", a_bs, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", a_bs, 2'b00);
    chk("mrst_flushes", {a_fd, a_fe, a_fm}, 3'b111);
    chk("mrst_stalls", {a_sf, a_sd, a_se, a_sm}, 4'b0000);
    next_cycle();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #4;
    chk("mrst_after_busy", a_bs, 2'b00);
    chk("mrst_after_outs", {a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fm}, 7'b0000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_seq.md
Name: pipe_hazard_seq

Overview:
- Central stall/flush sequencer for the 5-stage RV32 core with branch prediction.
- Merges redirect requests from E (pc_src), load-use hazards from D, multi-cycle execute ops (mul/div) and the data-memory req/ack handshake.
- Produces per-stage stall and flush controls.
- Holds an FSM for long stalls and counts redirect and stall cycles for performance monitoring.

Parameters:
- CNT_W, 32, width of the redirect_cnt and stall_cnt counters (saturating).
- EX_TIMEOUT, 64, maximum cycles in EX_WAIT before forced exit with error.
- TO_W, 7, width of the EX_WAIT cycle counter; must hold EX_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- pc_src  in  3  E-stage next-PC select:
  - 000: PC+4
  - 001: predicted-taken redirect from D
  - 010, 011, 101: mispredict/jump redirect from E
  - 100, 110, 111: treated as 000
- load_use  in  1  D-stage load-use hazard detected
- ex_start  in  1  multi-cycle op in E issues this cycle
- ex_done  in  1  multi-cycle unit result valid
- mem_req  in  1  M-stage load/store request outstanding
- mem_ack  in  1  data memory completes request
- ctr_clr  in  1  synchronous clear of both counters
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold stage register
- flush_d, flush_e, flush_m  out  1 each  insert bubble into stage register
- busy_state  out  2  00 RUN, 01 EX_WAIT, 10 MEM_WAIT
- ex_timeout_err  out  1  sticky: EX_WAIT timed out
- redirect_cnt  out  CNT_W  redirects applied
- stall_cnt  out  CNT_W  cycles with stall_f=1

Behaviour:
- Reset (rst_n=0, async):
  - state RUN; counters, timeout counter and ex_timeout_err cleared.
  - While rst_n=0: all stalls 0; flush_d=flush_e=flush_m=1.
- Redirect classes:
  - major = pc_src in {010, 011, 101}: flush_d=1, flush_e=1.
  - minor = 001: flush_e=1 only.
- RUN state, evaluated in priority order:
  1. mem_req & !mem_ack: all four stalls 1, no flushes; next state MEM_WAIT.
  2. ex_start: stall_f/d/e=1, flush_m=1; next state EX_WAIT; timeout counter := 0. Any redirect is not applied this cycle.
  3. Major redirect: apply flushes, no stalls; load_use ignored.
  4. Minor redirect with load_use: stall_f=stall_d=1, flush_e=1.
  5. Minor redirect alone: flush_e=1.
  6. load_use alone: stall_f=stall_d=1, flush_e=1.
  7. Otherwise: all outputs 0.
- mem_req & mem_ack in the same cycle completes with no stall.
- MEM_WAIT state:
  - All stalls 1, no flushes.
  - On mem_ack: this cycle still stalls; next state RUN. Any pending redirect is applied in the first RUN cycle.
  - pc_src and load_use are ignored while stalled. The E instruction is frozen, so pc_src is re-evaluated after release.
- EX_WAIT state:
  - stall_f/d/e=1, flush_m=1; timeout counter increments each cycle.
  - On ex_done: stall_f/d/e=0, flush_m=0. A redirect or load_use present this cycle is applied per the RUN rules 3–6. Next state RUN.
  - ex_done in the same cycle as ex_start (RUN) is ignored; the unit takes ≥1 cycle.
  - Counter reaching EX_TIMEOUT-1 without ex_done: set ex_timeout_err; next state RUN; release stalls that cycle with flush_e=1, which drops the hung op.
  - mem_req is not sampled in EX_WAIT; M holds a bubble.
- Counters, saturating at all-ones:
  - redirect_cnt +1 on every cycle a major or minor redirect flush is actually asserted.
  - stall_cnt +1 on every cycle stall_f=1.
  - ctr_clr has priority over increment.
- Outputs are combinational from state and inputs; there is no latency beyond this. State and counters update on posedge clk.
- Reset asserted mid-EX_WAIT or mid-MEM_WAIT returns immediately to RUN with the reset output values.

Test Plan:
- Reset, then pc_src=011 with load_use=1 in RUN → flush_d=1, flush_e=1, stall_f=0; redirect_cnt=1 next cycle.
- load_use=1 for 1 cycle, pc_src=000 → stall_f=stall_d=1, flush_e=1; stall_cnt=1.
- mem_req=1, mem_ack delayed 3 cycles, pc_src=010 held throughout:
  - 4 cycles with all stalls 1, busy_state=10.
  - Flushes only in the first cycle after ack; redirect_cnt=1.
- ex_start pulse, ex_done on the 5th following cycle → 5 cycles of stall_f/d/e=1 with flush_m=1; release on the ex_done cycle; stall_cnt=5.
- EX_TIMEOUT=4, ex_start, no ex_done → exit after 4 EX_WAIT cycles with flush_e=1, ex_timeout_err=1 sticky until reset.
- Saturation and clear:
  - CNT_W=3: 8 redirects → redirect_cnt stays 7.
  - ctr_clr with a simultaneous redirect → 0.
  - rst_n low mid-MEM_WAIT → busy_state=00, all flushes 1.
